mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  async active-low reset.
REQ-004 md_op  input  3  EX-stage MD operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-005 opA  input  32  rs operand, forwarded value at EX.
REQ-006 opB  input  32  rt operand, forwarded value at EX.
REQ-007 dis  input  1  disable from pipeline control (flush cycle); suppresses acceptance of md_op this cycle.
REQ-008 busy  output  1  to pipeline control as MDBusy; combinational OR of accepted start and internal busy.
REQ-009 hi  output  32  HI register value.
REQ-010 lo  output  32  LO register value.

Function
REQ-011 Parameters: MUL_LAT default 5, meaning the multiply busy cycles after the start edge; DIV_LAT default 10, meaning the divide busy cycles after the start edge.
REQ-012 FSM states SHALL be IDLE, MUL and DIV, with a 4-bit down-counter cnt.
REQ-013 Accept condition: start = (md_op in 1..4) && !dis && state==IDLE; a start presented in any other case SHALL be ignored with no state change.
REQ-014 On the start edge, the block SHALL latch the operands and the signed/unsigned flag, load cnt with the latency minus 1, and move to MUL (ops 1/2) or DIV (ops 3/4).
REQ-015 In MUL/DIV, cnt SHALL decrement once per cycle; on the edge where cnt==0, hi/lo SHALL be written and the state SHALL return to IDLE.
REQ-016 busy SHALL equal start || (state!=IDLE): high in the start cycle and for exactly MUL_LAT/DIV_LAT following cycles; low in the cycle hi/lo first show the result.
REQ-017 MULT SHALL compute the signed 64-bit product; MULTU SHALL compute the unsigned 64-bit product; {hi,lo} = product[63:0].
REQ-018 DIV SHALL perform signed division with the quotient truncated toward zero: lo = quotient, hi = remainder, and the remainder takes the sign of the dividend.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-020 DIVU SHALL perform unsigned division: lo = quotient, hi = remainder.
REQ-021 Divide by zero (opB==0 for ops 3/4) SHALL still run the full DIV_LAT busy period, then leave hi/lo unchanged.
REQ-022 MTHI/MTLO with !dis and state==IDLE SHALL write opA to hi/lo respectively on the next edge, with zero latency and no busy assertion.
REQ-023 MTHI/MTLO while state!=IDLE SHALL be ignored; pipeline control stalls this case, so it is unreachable in normal operation.
REQ-024 dis SHALL NOT abort an in-flight operation; the in-flight op belongs to an older, committed instruction and SHALL complete normally.
REQ-025 An op presented while dis is high SHALL have no effect on state, cnt, hi or lo.
REQ-026 hi/lo SHALL change only on a completion edge or an accepted MTHI/MTLO edge, and SHALL hold otherwise.
REQ-027 A new start SHALL be accepted in the cycle after completion (state==IDLE), giving back-to-back throughput of one op per latency+1 cycles.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, cnt=0, hi=0, lo=0 and the latched operands to 0.
REQ-029 While reset_n is low, busy SHALL be 0 regardless of md_op.
REQ-030 Reset asserted mid-operation SHALL discard the operation, leaving hi/lo = 0 after release.
REQ-031 The first accepted start SHALL be on the first rising edge with reset_n high.

Verification
REQ-032 MULT with opA=0xFFFFFFFE (-2) and opB=3 -> busy high for the start cycle plus 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 MULTU with opA=opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-034 DIV with opA=-7 (0xFFFFFFF9) and opB=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 with prior hi=0x11 and lo=0x22 -> 10 busy cycles, then hi/lo still 0x11/0x22.
REQ-035 MULT started with dis=1 in the same cycle -> busy low, hi/lo unchanged; dis pulse during an in-flight DIV -> result still written at the normal edge.
REQ-036 MTLO of 0xDEADBEEF at IDLE -> lo=0xDEADBEEF the next cycle with busy never high; MTHI issued during a MULT -> ignored, and the MULT result is intact.
REQ-037 reset_n pulsed low at cycle 3 of a DIV -> busy=0 immediately, hi=lo=0 and state IDLE; a new MULT accepted right after release completes correctly.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit: EX-stage request and HI/LO results.
interface mult_div_unit_if;
   logic [2:0]  md_op;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        dis;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_op, opA, opB, dis,
      input  busy, hi, lo
   );

   modport slave (
      input  md_op, opA, opB, dis,
      output busy, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and zero-latency MTHI/MTLO.
module mult_div_unit #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input logic             clk,
   input logic             reset_n,
   mult_div_unit_if.slave  md_bus
);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        sgn_q, sgn_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   logic        is_md, idle, start;
   logic [63:0] mul_a, mul_b, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

   // Accept decode and arithmetic on the latched operands.
   always_comb begin
      is_md = (md_bus.md_op >= OpMult) && (md_bus.md_op <= OpDivu);
      idle  = (state_q == StIdle);
      start = is_md && !md_bus.dis && idle;

      // Low 64 bits of the 64x64 product of the extended operands is the signed/unsigned result.
      mul_a = {{32{sgn_q & a_q[31]}}, a_q};
      mul_b = {{32{sgn_q & b_q[31]}}, b_q};
      prod  = mul_a * mul_b;

      // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
      a_neg  = sgn_q & a_q[31];
      b_neg  = sgn_q & b_q[31];
      a_mag  = a_neg ? -a_q : a_q;
      b_mag  = b_neg ? -b_q : b_q;
      b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem    = a_neg ? -r_mag : r_mag;
   end

   // Next-state: start/MTxx in idle, countdown and result write in MUL/DIV.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d   = md_bus.opA;
               b_d   = md_bus.opB;
               sgn_d = (md_bus.md_op == OpMult) || (md_bus.md_op == OpDiv);
               if ((md_bus.md_op == OpMult) || (md_bus.md_op == OpMultu)) begin
                  state_d = StMul;
                  cnt_d   = 4'(MUL_LAT - 1);
               end else begin
                  state_d = StDiv;
                  cnt_d   = 4'(DIV_LAT - 1);
               end
            end else if (!md_bus.dis && (md_bus.md_op == OpMthi)) begin
               hi_d = md_bus.opA;
            end else if (!md_bus.dis && (md_bus.md_op == OpMtlo)) begin
               lo_d = md_bus.opA;
            end
         end
         StMul: begin
            if (cnt_q == 4'd0) begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDiv: begin
            if (cnt_q == 4'd0) begin
               // Divide by zero burns the full latency but leaves HI/LO alone.
               if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counter, operand latches and HI/LO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // busy is forced low during reset even if a start is being presented.
   always_comb begin
      md_bus.busy = reset_n && (start || (state_q != StIdle));
      md_bus.hi   = hi_q;
      md_bus.lo   = lo_q;
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: inputs driven and outputs sampled on the falling edge.
module tb_mult_div_unit;

   localparam logic [2:0] OpNone  = 3'd0;
   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_bad;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mult_div_unit_if md_if ();

   mult_div_unit #(
      .MUL_LAT (5),
      .DIV_LAT (10)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md_bus  (md_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Issue a multi-cycle op at a falling edge, optionally injecting one request mid-flight,
   // then check latency, HI/LO hold while busy, and the final result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int inj_at, input logic [2:0] inj_op,
                         input logic inj_dis, input logic [31:0] inj_a);
      int n;
      md_if.md_op = op;
      md_if.opA   = a;
      md_if.opB   = b;
      md_if.dis   = 1'b0;
      #1;
      check_val({tag, "_busy_start"}, 64'(md_if.busy), 64'd1);
      @(negedge clk);
      md_if.md_op = OpNone;
      n = 0;
      while (md_if.busy && (n < 40)) begin
         check_val({tag, "_hold_hi"}, 64'(md_if.hi), 64'(hi_m));
         check_val({tag, "_hold_lo"}, 64'(md_if.lo), 64'(lo_m));
         n++;
         if (n == inj_at) begin
            md_if.md_op = inj_op;
            md_if.dis   = inj_dis;
            md_if.opA   = inj_a;
         end
         @(negedge clk);
         md_if.md_op = OpNone;
         md_if.dis   = 1'b0;
      end
      check_val({tag, "_lat"}, 64'(n), 64'(lat));
      check_val({tag, "_hi"}, 64'(md_if.hi), 64'(exp_hi));
      check_val({tag, "_lo"}, 64'(md_if.lo), 64'(exp_lo));
      hi_m = exp_hi;
      lo_m = exp_lo;
   endtask

   // Zero-latency MTHI/MTLO issued at a falling edge.
   task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      md_if.md_op = op;
      md_if.opA   = a;
      md_if.dis   = 1'b0;
      #1;
      check_val({tag, "_busy_issue"}, 64'(md_if.busy), 64'd0);
      @(negedge clk);
      md_if.md_op = OpNone;
      #1;
      check_val({tag, "_busy_after"}, 64'(md_if.busy), 64'd0);
      check_val({tag, "_hi"}, 64'(md_if.hi), 64'(exp_hi));
      check_val({tag, "_lo"}, 64'(md_if.lo), 64'(exp_lo));
      hi_m = exp_hi;
      lo_m = exp_lo;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk = 0;
      n_bad = 0;
      hi_m  = 32'd0;
      lo_m  = 32'd0;
      reset_n     = 1'b0;
      md_if.md_op = OpMult;
      md_if.opA   = 32'd5;
      md_if.opB   = 32'd5;
      md_if.dis   = 1'b0;

      // Reset state, with a MULT presented throughout
      @(negedge clk);
      @(negedge clk);
      check_val("rst_busy", 64'(md_if.busy), 64'd0);
      check_val("rst_hi", 64'(md_if.hi), 64'd0);
      check_val("rst_lo", 64'(md_if.lo), 64'd0);
      reset_n     = 1'b1;
      md_if.md_op = OpNone;

      // Arithmetic cases, issued back to back
      run_op("mult_neg", OpMult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
             0, OpNone, 1'b0, 32'd0);
      run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE,
             32'h0000_0001, 0, OpNone, 1'b0, 32'd0);
      run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             0, OpNone, 1'b0, 32'd0);
      run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000,
             0, OpNone, 1'b0, 32'd0);
      run_op("divu", OpDivu, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0, OpNone, 1'b0, 32'd0);

      // Divide by zero leaves HI/LO untouched
      do_mt("mthi", OpMthi, 32'h11, 32'h11, 32'd14);
      do_mt("mtlo", OpMtlo, 32'h22, 32'h11, 32'h22);
      run_op("divu_zero", OpDivu, 32'd7, 32'd0, 10, 32'h11, 32'h22, 0, OpNone, 1'b0, 32'd0);

      // Start suppressed by dis
      md_if.md_op = OpMult;
      md_if.opA   = 32'd3;
      md_if.opB   = 32'd4;
      md_if.dis   = 1'b1;
      #1;
      check_val("dis_busy", 64'(md_if.busy), 64'd0);
      @(negedge clk);
      md_if.md_op = OpNone;
      md_if.dis   = 1'b0;
      #1;
      check_val("dis_busy_after", 64'(md_if.busy), 64'd0);
      check_val("dis_hi", 64'(md_if.hi), 64'h11);
      check_val("dis_lo", 64'(md_if.lo), 64'h22);
      @(negedge clk);

      // dis pulse mid-DIV does not abort it; 100 / -7 = -14 rem 2
      run_op("div_dis", OpDiv, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2,
             4, OpDiv, 1'b1, 32'd1);

      // MTLO at idle, then MTHI during a MULT is ignored
      do_mt("mtlo_dead", OpMtlo, 32'hDEAD_BEEF, 32'd2, 32'hDEAD_BEEF);
      run_op("mult_mthi", OpMult, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0,
             2, OpMthi, 1'b0, 32'h0000_AAAA);

      // Reset in the middle of a DIV
      md_if.md_op = OpDiv;
      md_if.opA   = 32'd100;
      md_if.opB   = 32'd3;
      #1;
      check_val("rstmid_busy_start", 64'(md_if.busy), 64'd1);
      @(negedge clk);
      md_if.md_op = OpNone;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_val("rstmid_busy", 64'(md_if.busy), 64'd0);
      check_val("rstmid_hi", 64'(md_if.hi), 64'd0);
      check_val("rstmid_lo", 64'(md_if.lo), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      hi_m = 32'd0;
      lo_m = 32'd0;
      run_op("mult_after_rst", OpMult, 32'd7, 32'd6, 5, 32'd0, 32'd42, 0, OpNone, 1'b0, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
